pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage in-order pipeline.
//
// Produces per-stage hold (stall*) and bubble (flush*) controls for the F/D/E/M/W
// pipeline registers from data-bus waits, multi-cycle execute and load-use hazards.
// It also sequences E-stage redirects into the PC. If a redirect arrives while
// a fetch is in flight, the target is parked in tgt_q. The stale instruction
// is dropped when that fetch returns.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ireq_busy           fetch waiting on instruction bus
//   dreq_busy           M-stage access waiting on data bus
//   ex_busy             multi-cycle E unit not done
//   load_use            D sources a load destination in E
//   redirect_valid/pc   redirect request and target from E
//   stallF/D/E/M        hold pipeline registers
//   flushD/E/M/W        load bubble into pipeline registers
//   pc_we, pc_next      PC write strobe and redirect target
//   redir_pending       redirect parked waiting for the fetch to return
//   perf_stall_cnt      cycles with stallF=1 (optional)
//   perf_flush_cnt      accepted redirects (optional)
//
// Optional feature macro: PIPE_HAZARD_PERF_EN enables the two performance
// counters. When the macro is undefined, both counter ports are tied to 0.

module pipe_hazard_ctrl #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ireq_busy,
  input  logic             dreq_busy,
  input  logic             ex_busy,
  input  logic             load_use,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             pc_we,
  output logic [PC_W-1:0]  pc_next,
  output logic             redir_pending,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic [0:0] {StRun, StWaitFetch} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic              redir_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    redir_accept  = 1'b0;
    stallF        = 1'b0;
    stallD        = 1'b0;
    stallE        = 1'b0;
    stallM        = 1'b0;
    flushD        = 1'b0;
    flushE        = 1'b0;
    flushM        = 1'b0;
    flushW        = 1'b0;
    pc_we         = 1'b0;
    pc_next       = '0;
    redir_pending = 1'b0;

    // Priority stall sources; each stalled stage bubbles the first unstalled one after it.
    if (dreq_busy) begin
      {stallF, stallD, stallE, stallM} = 4'b1111;
      flushW = 1'b1;
    end else if (ex_busy) begin
      {stallF, stallD, stallE} = 3'b111;
      flushM = 1'b1;
    end else if (load_use) begin
      {stallF, stallD} = 2'b11;
      flushE = 1'b1;
    end

    unique case (state_q)
      StRun: begin
        // stallE=0 here means only a load-use stall can be active; the redirect kills
        // both younger instructions, so that stall is moot.
        if (redirect_valid && !stallE) begin
          redir_accept = 1'b1;
          flushD       = 1'b1;
          flushE       = 1'b1;
          stallF       = 1'b0;
          stallD       = 1'b0;
          if (!ireq_busy) begin
            pc_we   = 1'b1;
            pc_next = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = StWaitFetch;
          end
        end
      end
      StWaitFetch: begin
        redir_pending = 1'b1;
        pc_next       = tgt_q;
        if (ireq_busy) begin
          stallF = 1'b1;
        end else if (!dreq_busy) begin
          // Fetch returned: write the parked target and drop the stale instruction.
          pc_we   = 1'b1;
          flushD  = 1'b1;
          state_d = StRun;
        end
      end
    endcase

    if (reset) begin
      {stallF, stallD, stallE, stallM} = 4'b0000;
      {flushD, flushE, flushM, flushW} = 4'b1111;
      pc_we         = 1'b0;
      pc_next       = '0;
      redir_pending = 1'b0;
      redir_accept  = 1'b0;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallF)       stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir_accept) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  logic unused_redir_accept;
  assign unused_redir_accept = redir_accept;
  assign perf_stall_cnt      = '0;
  assign perf_flush_cnt      = '0;
`endif

`ifndef SYNTHESIS
  // E holds a bubble while a redirect is parked, so a new redirect here is a pipeline bug.
  assert property (@(posedge clk) disable iff (reset)
                   !(state_q == StWaitFetch && redirect_valid));
`endif

endmodule
